// File: rtl/hamming_scrub_decoder.sv
// Sequential Hamming(7,4) check-and-correct engine: one 4-bit block per cycle,
// returning the corrected codeword, per-block error flags and a saturating count.
module hamming_scrub_decoder #(
  parameter int WIDTH       = 16,
  parameter int BLOCKS      = WIDTH / 4,
  parameter int PARITY_BITS = BLOCKS * 3,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [PARITY_BITS-1:0] in_parity,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [PARITY_BITS-1:0] out_parity,
  output logic [BLOCKS-1:0]      err_mask,
  output logic [CNT_W-1:0]       corr_count,
  input  logic                   count_clr
);

  localparam int IDX_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, DONE = 2'd2} state_t;

  // Parity bits {q2, q1, q0} of one data nibble.
  function automatic logic [2:0] calc_parity(input logic [3:0] d);
    return {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
  endfunction

  // Syndrome to flip pattern laid out as {p[2:0], d[3:0]}.
  function automatic logic [6:0] flip_mask(input logic [2:0] s);
    logic [6:0] f;
    case (s)
      3'b111:  f = 7'b000_0001;
      3'b011:  f = 7'b000_0010;
      3'b101:  f = 7'b000_0100;
      3'b110:  f = 7'b000_1000;
      3'b001:  f = 7'b001_0000;
      3'b010:  f = 7'b010_0000;
      3'b100:  f = 7'b100_0000;
      default: f = 7'b000_0000;
    endcase
    return f;
  endfunction

  state_t                 state_q;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [PARITY_BITS-1:0] parity_q, parity_d;
  logic [BLOCKS-1:0]      err_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q;
  logic                   in_ready_q, out_valid_q;
  logic [3:0]             blk_d_s;
  logic [2:0]             blk_p_s, syn_s;
  logic [6:0]             fix_s;

  // Correct the currently indexed block and compute the next counter value.
  always_comb begin
    blk_d_s  = data_q[4*idx_q +: 4];
    blk_p_s  = parity_q[3*idx_q +: 3];
    syn_s    = blk_p_s ^ calc_parity(blk_d_s);
    fix_s    = flip_mask(syn_s);
    data_d   = data_q;
    parity_d = parity_q;
    data_d[4*idx_q +: 4]   = blk_d_s ^ fix_s[3:0];
    parity_d[3*idx_q +: 3] = blk_p_s ^ fix_s[6:4];
    // Clear takes priority over a same-cycle correction.
    if (count_clr) begin
      cnt_d = '0;
    end else if ((state_q == CHECK) && (syn_s != 3'b000) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      parity_q    <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= in_data;
            parity_q   <= in_parity;
            err_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          data_q   <= data_d;
          parity_q <= parity_d;
          if (syn_s != 3'b000) begin
            err_q[idx_q] <= 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = data_q;
  assign out_parity = parity_q;
  assign err_mask   = err_q;
  assign corr_count = cnt_q;

endmodule

// File: doc/hamming_scrub_decoder.md
Name: hamming_scrub_decoder

Overview:
- Sequential Hamming(7,4) check-and-correct engine, the read side of the team's parity-protected counter path.
- Accepts a stored data word plus its per-nibble parity through a valid/ready handshake.
- Checks one 4-bit block per cycle, fixes any single-bit error per block in data or parity, and returns the corrected codeword with per-block error flags and a saturating correction count.
- Sits between parity-protected storage and its consumer; also used as a background scrubber.

Parameters:
- width, 16, data word width; must be a multiple of 4.
- blocks, width/4, number of 4-bit Hamming blocks.
- parity_bits, blocks*3, total stored parity bits.
- cnt_w, 8, width of the correction counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  codeword offered.
- in_ready  output  1  engine can accept a codeword.
- in_data  input  width  stored data word.
- in_parity  input  parity_bits  stored parity; bits [3i+2:3i] belong to data block i.
- out_valid  output  1  corrected result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  width  corrected data.
- out_parity  output  parity_bits  corrected parity.
- err_mask  output  blocks  bit i set if block i needed a correction.
- corr_count  output  cnt_w  running count of corrected blocks; saturating.
- count_clr  input  1  synchronous clear of corr_count.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - in_ready=1, out_valid=0.
  - out_data, out_parity, err_mask, corr_count and the block index all go to 0.
- FSM states: IDLE, CHECK, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture in_data and in_parity, clear err_mask, set index=0, go to CHECK.
- CHECK:
  - in_ready=0, out_valid=0.
  - Each edge processes block idx, with d=data[4idx+3:4idx] and p=parity[3idx+2:3idx].
  - Recompute q2=d0^d2^d3, q1=d0^d1^d3, q0=d0^d1^d2; syndrome s=p^q.
  - Syndrome decode, always single-bit:
    - 000: no change.
    - 111: flip d0.
    - 011: flip d1.
    - 101: flip d2.
    - 110: flip d3.
    - 001: flip p0.
    - 010: flip p1.
    - 100: flip p2.
  - Any nonzero s: set err_mask[idx]; increment corr_count by 1, saturating at 2^cnt_w-1 (no wrap).
  - After processing idx=blocks-1, go to DONE; otherwise idx+1.
- DONE:
  - out_valid=1; out_data, out_parity and err_mask are stable and held.
  - On an edge with out_ready=1, go to IDLE. in_ready returns to 1 the following cycle; there is no same-cycle re-accept.
- Latency: acceptance edge E0, then blocks processed at E1..E_blocks; out_valid is high after E_blocks (4 cycles for default width).
- in_data/in_parity changes after acceptance have no effect.
- count_clr:
  - When asserted, corr_count=0 at the next edge.
  - If it coincides with an increment, clear wins and the increment is dropped.
- Outputs from the previous result stay on out_data/out_parity/err_mask while in IDLE, until the next acceptance clears err_mask.
- Reset mid-CHECK or mid-DONE aborts the result immediately: out_valid=0, state IDLE, corr_count=0.
- Double-bit errors in one block are miscorrected as single errors by design; no detection is required.

Test Plan:
- Clean word: in_data=0x0001, in_parity=0x007 -> out_data=0x0001, out_parity=0x007, err_mask=0000, corr_count=0, out_valid high 4 cycles after acceptance.
- Data flip: in_data=0x0000, in_parity=0x007 (block0 s=111) -> out_data=0x0001, out_parity=0x007, err_mask=0001, corr_count=1.
- Parity flip: in_data=0x0000, in_parity=0x010 (block1 s=010) -> out_data=0x0000, out_parity=0x000, err_mask=0010, corr_count increments by 1.
- Multi-block: in_data=0x7FFD, in_parity=0xFFF -> out_data=0xFFFF, out_parity=0xFFF, err_mask=1001, corr_count increments by 2.
- Backpressure/handshake: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0 throughout. Pulse out_ready -> IDLE, in_ready=1 next cycle. A second word offered during CHECK is not accepted until IDLE.
- Saturation/clear/reset: cnt_w=2, feed 5 single-error words -> corr_count stops at 3. Assert count_clr on a correcting cycle -> corr_count=0. Assert rst during CHECK -> out_valid=0, in_ready=1, all outputs 0.
